cms_trace_packer: RTL

Parametrised successor of the continuous monitoring system packet path. It captures per-instruction trace packets (instr, pc, N programmable event-counter channels, overflow flag) into an internal FIFO and drains them over an AXI-Stream master with configurable TLAST framing. Channel-to-event mapping and drop accounting are controlled through the existing addr/wdata/write-enable control port. It sits between the RISC-V core trace taps and the AXI DMA FIFO.

---
 rtl/cms_trace_packer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cms_trace_packer.sv
// cms_trace_packer: captures retire-time trace packets (instr, pc, event
// counter channels, overflow flag, optional timestamp) into a FIFO and
// streams them out as AXI-Stream beats with programmable TLAST framing.
// Optional feature macro: CMS_TRACE_PACKER_TIMESTAMP_EN adds a 32-bit
// free-running cycle stamp after the overflow flag in each packet.
module cms_trace_packer #(
  parameter int XLEN                                = 64,
  parameter int INSTR_WIDTH                         = 32,
  parameter int NUM_EVENTS                          = 39,
  parameter int NUM_CHANNELS                        = 3,
  parameter int COUNTER_WIDTH                       = 7,
  parameter int FIFO_DEPTH                          = 8,
  parameter int AXI_DATA_WIDTH                      = 512,
  parameter int CTRL_ADDR_WIDTH                     = 8,
  parameter int CTRL_DATA_WIDTH                     = 64,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          pc_valid,
  input  logic [INSTR_WIDTH-1:0]        instr,
  input  logic [XLEN-1:0]               pc,
  input  logic [NUM_EVENTS-1:0]         performance_events,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  input  logic [31:0]                   tlast_interval,
  input  logic [CTRL_ADDR_WIDTH-1:0]    ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]    ctrl_wdata,
  input  logic                          ctrl_write_enable,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef CMS_TRACE_PACKER_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  localparam int OFF_PC = INSTR_WIDTH;
  localparam int OFF_CH = INSTR_WIDTH + XLEN;
  localparam int OFF_OV = OFF_CH + NUM_CHANNELS * COUNTER_WIDTH;
  localparam int OFF_TS = OFF_OV + 1;
  localparam int PKT_W  = OFF_TS + TS_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int SEL_W  = $clog2(NUM_EVENTS) + 1;

  localparam logic [LW-1:0]            DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  generate
    if (PKT_W > AXI_DATA_WIDTH) begin : g_width_check
      $error("cms_trace_packer: packet width exceeds AXI_DATA_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_check
      $error("cms_trace_packer: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic                     we_q;
  logic                     wr_stb;
  logic                     soft_clr;
  logic                     clr_drop;
  logic [SEL_W-1:0]         sel     [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt     [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_inc [NUM_CHANNELS];
  logic                     ev_sel  [NUM_CHANNELS];
  logic                     ovf_flag;
  logic                     capture;
  logic                     pop;
  logic                     full;
  logic                     push_ok;
  logic                     drop;
  logic [LW-1:0]            wr_ptr;
  logic [LW-1:0]            rd_ptr;
  logic [PKT_W-1:0]         mem [FIFO_DEPTH];
  logic [PKT_W-1:0]         pkt;
  logic [31:0]              beat_cnt;
  logic                     tlast_int;
  logic                     unused_ctrl_wdata;

  assign unused_ctrl_wdata = ^ctrl_wdata[CTRL_DATA_WIDTH-1:SEL_W];

`ifdef CMS_TRACE_PACKER_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // In posedge mode a held strobe yields a single write.
  assign wr_stb   = (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ?
                    (ctrl_write_enable & ~we_q) : ctrl_write_enable;
  assign soft_clr = wr_stb && (ctrl_addr == '0) && ctrl_wdata[0];
  assign clr_drop = wr_stb && (ctrl_addr == CTRL_ADDR_WIDTH'(16));

  assign capture       = en & pc_valid;
  assign M_AXIS_tvalid = (wr_ptr != rd_ptr);
  assign fifo_level    = wr_ptr - rd_ptr;
  assign full          = (fifo_level == DEPTH_L);
  assign pop           = M_AXIS_tvalid & M_AXIS_tready;
  // A soft clear discards a same-cycle capture without counting it as a drop.
  assign push_ok       = capture & ~soft_clr & (~full | pop);
  assign drop          = capture & ~soft_clr & full & ~pop;

  assign tlast_int    = (tlast_interval != 32'd0) && (beat_cnt >= tlast_interval - 32'd1);
  assign M_AXIS_tlast = M_AXIS_tvalid & tlast_int;

  // Registered copy of the write strobe for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) we_q <= 1'b0;
    else     we_q <= ctrl_write_enable;
  end

  // Channel selector registers; out-of-range selectors count nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHANNELS; k++) sel[k] <= SEL_W'(k);
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (wr_stb && (ctrl_addr == CTRL_ADDR_WIDTH'(k + 1)))
          sel[k] <= ctrl_wdata[SEL_W-1:0];
      end
    end
  end

  // Event mux and saturating increment including the current-cycle pulse.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      ev_sel[k] = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (sel[k] == SEL_W'(e)) ev_sel[k] = performance_events[e];
      end
      cnt_inc[k] = (cnt[k] == CNT_MAX) ? CNT_MAX : cnt[k] + COUNTER_WIDTH'(ev_sel[k]);
    end
  end

  // Channel counters: clear on accepted capture, keep accumulating on a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHANNELS; k++) cnt[k] <= '0;
    end else if (soft_clr || push_ok) begin
      for (int k = 0; k < NUM_CHANNELS; k++) cnt[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NUM_CHANNELS; k++) cnt[k] <= cnt_inc[k];
    end
  end

  // Sticky overflow flag, consumed by the next accepted packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_flag <= 1'b0;
    else if (soft_clr) ovf_flag <= 1'b0;
    else if (drop)     ovf_flag <= 1'b1;
    else if (push_ok)  ovf_flag <= 1'b0;
  end

  // Packet assembly, LSB first, zero above the last field.
  always_comb begin
    pkt = '0;
    pkt[0 +: INSTR_WIDTH] = instr;
    pkt[OFF_PC +: XLEN]   = pc;
    for (int k = 0; k < NUM_CHANNELS; k++)
      pkt[OFF_CH + k * COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_inc[k];
    pkt[OFF_OV] = ovf_flag;
`ifdef CMS_TRACE_PACKER_TIMESTAMP_EN
    pkt[OFF_TS +: 32] = ts_cnt;
`endif
  end

  // FIFO storage; contents are qualified by the pointers so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= pkt;
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LW'(1);
      if (pop)     rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // First-word fall-through head, forced to zero when empty.
  always_comb begin
    M_AXIS_tdata = '0;
    if (M_AXIS_tvalid) M_AXIS_tdata[PKT_W-1:0] = mem[rd_ptr[AW-1:0]];
  end

  // Beat counter for TLAST framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           beat_cnt <= '0;
    else if (soft_clr) beat_cnt <= '0;
    else if (pop)      beat_cnt <= tlast_int ? 32'd0 : beat_cnt + 32'd1;
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               drop_count <= '0;
    else if (clr_drop)                     drop_count <= '0;
    else if (drop && (drop_count != '1))   drop_count <= drop_count + 32'd1;
  end

endmodule
